mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  Memory-access pipeline stage of the lc3b pipeline, directly upstream of WB.
//  Takes the EX/MEM latch contents and runs the data-memory transaction for LDW/LDB/STW/STB/LDI/STI.
//  Handles the two-access indirect sequence and stalls upstream until mem_resp arrives.
//  Registers mem_out, alu_out, br_addr_out and ipacket_out into the MEM/WB latch consumed by WB.
// PARAMETERS
//  STALL_CNT_W  16  width of the optional stall-cycle counter (used only with MEM_PERF_CNT_EN)
// PORTS
//  clk          in   1     single clock, rising edge
//  rst          in   1     asynchronous, active-high reset
//  ipacket_in   in   lc3b_ipacket  decoded control packet from EX/MEM latch
//  alu_in       in   16    EX result; effective address for memory ops
//  sr_data_in   in   16    store source register value
//  br_addr_in   in   16    branch/JSR target from EX
//  flush        in   1     pip_flush from WB: squash instruction held in this stage
//  mem_resp     in   1     data memory access complete (one-cycle pulse)
//  mem_rdata    in   16    data memory read data, valid with mem_resp
//  mem_read     out  1     data memory read strobe, held until mem_resp
//  mem_write    out  1     data memory write strobe, held until mem_resp
//  mem_address  out  16    data memory address
//  mem_wdata    out  16    data memory write data
//  mem_byte_en  out  2     byte enables {hi,lo}
//  stall        out  1     hold PC/IF/ID/EX latches this cycle
//  ipacket_out  out  lc3b_ipacket  to WB
//  alu_out      out  16    to WB alu_in
//  mem_out      out  16    to WB mem_in
//  br_addr_out  out  16    to WB br_addr
// BEHAVIOUR
//  Reset: state=IDLE; mem_read=mem_write=0; byte_en=0; ipacket_out=LC3B_BUBBLE; all word outputs=0.
//  is_mem: opcode in {LDW,LDB,LDI,STW,STB,STI}. is_ind: LDI or STI.
//  FSM states: IDLE, ACC1, ACC2.
//   IDLE: if is_mem && !flush -> ACC1; stall=1 this cycle (combinational).
//         Otherwise 1-cycle pass-through: latch the inputs, stall=0.
//   ACC1: access at alu_in; read for loads and indirects, write for STW/STB.
//         On mem_resp: if is_ind, latch ptr=mem_rdata and go to ACC2; else finish.
//   ACC2: access at ptr; LDI reads, STI writes sr_data_in. On mem_resp: finish.
//   finish: stall=0 that same cycle; MEM/WB latch loads; state -> IDLE.
//  stall=1 in ACC1/ACC2 until the cycle of the final mem_resp.
//   EX/MEM inputs must stay stable while stall=1.
//  While stall=1 the MEM/WB latch loads LC3B_BUBBLE, so WB never writes regfile/CC twice.
//  Widths and data formatting:
//   Word access: address {a[15:1],1'b0}; byte_en=2'b11.
//   Byte access: address = a; byte_en = a[0] ? 2'b10 : 2'b01.
//   STB: wdata = {sr[7:0], sr[7:0]}.
//   LDB: mem_out = sign-extend of selected byte (a[0]=1 selects [15:8]).
//   LDI pointer and final address are always word-aligned.
//  Strobe rules: strobes and address are registered and stable from entry to ACCx until mem_resp.
//   mem_read and mem_write are never high together.
//   Strobes deassert the cycle after mem_resp.
//   mem_resp outside ACC1/ACC2 is ignored.
//  flush:
//   In IDLE, the instruction becomes LC3B_BUBBLE and no access starts.
//   In ACC1/ACC2, the outstanding access completes (no bus abort), but no ACC2 is started.
//   The result is discarded as a bubble, and stall follows the normal rules.
//  Simultaneous flush and final mem_resp: flush wins; bubble is written.
//  Reset mid-access drops the strobes immediately; the transaction is abandoned.
// CONFIGURATION
//  MEM_PERF_CNT_EN defined: adds output stall_cycles [STALL_CNT_W-1:0].
//   Increments every cycle stall=1, saturates at all-ones, cleared by rst.
//  MEM_PERF_CNT_EN undefined: no port, no counter logic; behaviour otherwise identical.
// STRUCTURE
//  lc3b_types additions: lc3b_mem_state enum {IDLE,ACC1,ACC2}; LC3B_BUBBLE ipacket constant
//   (load_regfile=0, load_cc=0, opcode BR, nzp=000); is_mem/is_ind opcode helper functions.
//  One sub-module, mem_align: combinational byte-lane steering for wdata and byte_en,
//   plus LDB extraction and sign-extend.
//  FSM, strobe registers and MEM/WB latch live in mem_stage.
// TESTING
//  1. ADD, no mem op -> stall=0; next cycle alu_out=alu_in, ipacket_out=ipacket_in; no strobes.
//  2. LDW a=0x3001, mem_resp after 3 cycles, rdata=0xBEEF -> mem_address=0x3000, byte_en=11;
//     stall high 4 cycles; mem_out=0xBEEF.
//  3. LDB a=0x2001, rdata=0x8012 -> byte_en=10, mem_out=0xFF80.
//     STB a=0x2000, sr=0x12AB -> wdata=0xABAB, byte_en=01.
//  4. LDI a=0x4000, read1 rdata=0x5002, read2 rdata=0x1234 -> two reads (0x4000 then 0x5002);
//     mem_out=0x1234; WB sees exactly one non-bubble packet.
//  5. flush asserted in ACC1 of LDI -> first read completes, no second access, ipacket_out=bubble.
//  6. rst asserted mid-ACC2 -> strobes drop asynchronously; state=IDLE, outputs at reset values.
//     With MEM_PERF_CNT_EN: stall_cycles counts stall-high cycles and returns to 0.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared lc3b types for the MEM stage: opcodes, control packet, MEM FSM states,
// the bubble packet and opcode classification helpers.
package mem_stage_pkg;

    typedef enum logic [3:0] {
        OP_BR   = 4'h0,
        OP_ADD  = 4'h1,
        OP_LDB  = 4'h2,
        OP_STB  = 4'h3,
        OP_JSR  = 4'h4,
        OP_AND  = 4'h5,
        OP_LDW  = 4'h6,
        OP_STW  = 4'h7,
        OP_RTI  = 4'h8,
        OP_NOT  = 4'h9,
        OP_LDI  = 4'hA,
        OP_STI  = 4'hB,
        OP_JMP  = 4'hC,
        OP_SHF  = 4'hD,
        OP_LEA  = 4'hE,
        OP_TRAP = 4'hF
    } lc3b_opcode;

    typedef struct packed {
        lc3b_opcode  opcode;
        logic        load_regfile;
        logic        load_cc;
        logic [2:0]  nzp;
        logic [2:0]  dest;
    } lc3b_ipacket;

    typedef enum logic [1:0] {
        IDLE,
        ACC1,
        ACC2
    } lc3b_mem_state;

    // A never-taken BR that writes nothing: safe to hand to WB any number of times.
    localparam lc3b_ipacket LC3B_BUBBLE = '{
        opcode:       OP_BR,
        load_regfile: 1'b0,
        load_cc:      1'b0,
        nzp:          3'b000,
        dest:         3'b000
    };

    function automatic logic is_mem(input lc3b_opcode op);
        return op inside {OP_LDW, OP_LDB, OP_LDI, OP_STW, OP_STB, OP_STI};
    endfunction

    function automatic logic is_ind(input lc3b_opcode op);
        return op inside {OP_LDI, OP_STI};
    endfunction

    function automatic logic is_byte(input lc3b_opcode op);
        return op inside {OP_LDB, OP_STB};
    endfunction

endpackage

// File: rtl/mem_stage_align.sv
// Byte-lane steering for the data bus: address alignment, byte enables,
// store-data replication and LDB extract/sign-extend.
module mem_align (
    input  logic [15:0] ea,
    input  logic        byte_op,
    input  logic [15:0] sr_data,
    input  logic [15:0] rdata,
    output logic [15:0] address,
    output logic [1:0]  byte_en,
    output logic [15:0] wdata,
    output logic [15:0] ldb_data
);

    logic [7:0] sel_byte;

    assign address  = byte_op ? ea : {ea[15:1], 1'b0};
    assign byte_en  = byte_op ? (ea[0] ? 2'b10 : 2'b01) : 2'b11;
    // Replicating the byte lets memory pick the lane purely from byte_en.
    assign wdata    = byte_op ? {2{sr_data[7:0]}} : sr_data;
    assign sel_byte = ea[0] ? rdata[15:8] : rdata[7:0];
    assign ldb_data = {{8{sel_byte[7]}}, sel_byte};

endmodule

// File: rtl/mem_stage.sv
// lc3b MEM stage: runs LDW/LDB/STW/STB/LDI/STI data accesses, stalls upstream
// while busy and loads the MEM/WB latch. Optional MEM_PERF_CNT_EN adds stall_cycles.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int STALL_CNT_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  lc3b_ipacket ipacket_in,
    input  logic [15:0] alu_in,
    input  logic [15:0] sr_data_in,
    input  logic [15:0] br_addr_in,
    input  logic        flush,
    input  logic        mem_resp,
    input  logic [15:0] mem_rdata,
    output logic        mem_read,
    output logic        mem_write,
    output logic [15:0] mem_address,
    output logic [15:0] mem_wdata,
    output logic [1:0]  mem_byte_en,
    output logic        stall,
    output lc3b_ipacket ipacket_out,
    output logic [15:0] alu_out,
    output logic [15:0] mem_out,
    output logic [15:0] br_addr_out
`ifdef MEM_PERF_CNT_EN
    ,
    output logic [STALL_CNT_W-1:0] stall_cycles
`endif
);

    lc3b_mem_state state, state_nxt;
    logic          start, go_acc2, finish;
    logic          flush_pend;
    logic          mem_op, ind_op, byte_op, acc1_read;
    logic [15:0]   al_address, al_wdata, al_ldb;
    logic [1:0]    al_byte_en;
    logic [15:0]   load_data;

    assign mem_op    = is_mem(ipacket_in.opcode);
    assign ind_op    = is_ind(ipacket_in.opcode);
    assign byte_op   = is_byte(ipacket_in.opcode);
    // STI's first access fetches the pointer, so only STW/STB write first.
    assign acc1_read = !(ipacket_in.opcode inside {OP_STW, OP_STB});
    assign load_data = byte_op ? al_ldb : mem_rdata;

    mem_align u_align (
        .ea       (alu_in),
        .byte_op  (byte_op),
        .sr_data  (sr_data_in),
        .rdata    (mem_rdata),
        .address  (al_address),
        .byte_en  (al_byte_en),
        .wdata    (al_wdata),
        .ldb_data (al_ldb)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        start     = 1'b0;
        go_acc2   = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (mem_op && !flush) begin
                    start     = 1'b1;
                    stall     = 1'b1;
                    state_nxt = ACC1;
                end
            end
            ACC1: begin
                stall = 1'b1;
                if (mem_resp) begin
                    // A flush seen at any point in ACC1 suppresses the second access.
                    if (ind_op && !flush && !flush_pend) begin
                        go_acc2   = 1'b1;
                        state_nxt = ACC2;
                    end else begin
                        finish    = 1'b1;
                        stall     = 1'b0;
                        state_nxt = IDLE;
                    end
                end
            end
            ACC2: begin
                stall = 1'b1;
                if (mem_resp) begin
                    finish    = 1'b1;
                    stall     = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                            flush_pend <= 1'b0;
        else if (finish || state == IDLE)   flush_pend <= 1'b0;
        else if (flush)                     flush_pend <= 1'b1;
    end

    // Bus request registers: loaded on entry to each access, cleared after the final response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_address <= 16'h0000;
            mem_wdata   <= 16'h0000;
            mem_byte_en <= 2'b00;
        end else if (start) begin
            mem_read    <= acc1_read;
            mem_write   <= !acc1_read;
            mem_address <= al_address;
            mem_byte_en <= al_byte_en;
            mem_wdata   <= acc1_read ? 16'h0000 : al_wdata;
        end else if (go_acc2) begin
            mem_read    <= (ipacket_in.opcode == OP_LDI);
            mem_write   <= (ipacket_in.opcode == OP_STI);
            mem_address <= {mem_rdata[15:1], 1'b0};
            mem_byte_en <= 2'b11;
            mem_wdata   <= (ipacket_in.opcode == OP_STI) ? sr_data_in : 16'h0000;
        end else if (finish) begin
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_byte_en <= 2'b00;
        end
    end

    // MEM/WB latch; while stalled only bubbles reach WB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ipacket_out <= LC3B_BUBBLE;
            alu_out     <= 16'h0000;
            mem_out     <= 16'h0000;
            br_addr_out <= 16'h0000;
        end else if (stall) begin
            ipacket_out <= LC3B_BUBBLE;
        end else begin
            ipacket_out <= (flush || flush_pend) ? LC3B_BUBBLE : ipacket_in;
            alu_out     <= alu_in;
            br_addr_out <= br_addr_in;
            if (finish) mem_out <= load_data;
        end
    end

`ifdef MEM_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cycles <= '0;
        else if (stall && (stall_cycles != {STALL_CNT_W{1'b1}}))
            stall_cycles <= stall_cycles + 1'b1;
    end
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed cases then randomized instructions
// against a memory + transaction-level model of the stage.
module tb_mem_stage;
    import mem_stage_pkg::*;

    localparam int STALL_CNT_W = 16;

    logic        clk = 1'b0;
    logic        rst;
    lc3b_ipacket ipacket_in, ipacket_out;
    logic [15:0] alu_in, sr_data_in, br_addr_in, mem_rdata;
    logic [15:0] mem_address, mem_wdata, alu_out, mem_out, br_addr_out;
    logic        flush, mem_resp, mem_read, mem_write, stall;
    logic [1:0]  mem_byte_en;
`ifdef MEM_PERF_CNT_EN
    logic [STALL_CNT_W-1:0] stall_cycles;
`endif

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [1:0]  be;
        logic [15:0] wdata;
        int          lat;
    } acc_t;

    logic [15:0] mem_m [0:32767];
    acc_t        acc_q[$];
    int          checks = 0;
    int          failures = 0;
    int          tot_stall = 0;
    lc3b_ipacket bubble_exp;

    always #5 clk = ~clk;

    mem_stage #(.STALL_CNT_W(STALL_CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .ipacket_in  (ipacket_in),
        .alu_in      (alu_in),
        .sr_data_in  (sr_data_in),
        .br_addr_in  (br_addr_in),
        .flush       (flush),
        .mem_resp    (mem_resp),
        .mem_rdata   (mem_rdata),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_address (mem_address),
        .mem_wdata   (mem_wdata),
        .mem_byte_en (mem_byte_en),
        .stall       (stall),
        .ipacket_out (ipacket_out),
        .alu_out     (alu_out),
        .mem_out     (mem_out),
        .br_addr_out (br_addr_out)
`ifdef MEM_PERF_CNT_EN
        ,
        .stall_cycles(stall_cycles)
`endif
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Issue one instruction; l1/l2 = response latency of each access in cycles,
    // fl = cycle index (0 = issue cycle) at which flush pulses, -1 for none.
    task automatic run_instr(input lc3b_opcode op, input logic [15:0] a, input logic [15:0] sr,
                             input logic [15:0] br, input int l1, input int l2, input int fl);
        lc3b_ipacket p;
        acc_t        e;
        logic [15:0] w, exp_mem;
        logic [7:0]  bv;
        logic        m, ind, byt, ld, prev_stall, done;
        int          exp_stall, cyc, wait_cnt, stalls;

        p.opcode       = op;
        p.load_regfile = 1'($urandom);
        p.load_cc      = 1'($urandom);
        p.nzp          = 3'($urandom);
        p.dest         = 3'($urandom);
        m   = op inside {OP_LDW, OP_LDB, OP_LDI, OP_STW, OP_STB, OP_STI};
        ind = op inside {OP_LDI, OP_STI};
        byt = op inside {OP_LDB, OP_STB};
        ld  = op inside {OP_LDW, OP_LDB, OP_LDI};
        exp_stall = 0;
        exp_mem   = 16'h0000;
        acc_q.delete();

        if (m && fl != 0) begin
            e.wr    = (op == OP_STW) || (op == OP_STB);
            e.addr  = byt ? a : (a & 16'hFFFE);
            e.be    = !byt ? 2'b11 : ((a % 2) ? 2'b10 : 2'b01);
            e.wdata = (op == OP_STB) ? sr[7:0] * 16'h0101 : sr;
            e.lat   = l1;
            acc_q.push_back(e);
            exp_stall = l1;
            w = mem_m[e.addr >> 1];
            if (ind && !(fl >= 1 && fl <= l1)) begin
                e.wr    = (op == OP_STI);
                e.addr  = w & 16'hFFFE;
                e.be    = 2'b11;
                e.wdata = sr;
                e.lat   = l2;
                acc_q.push_back(e);
                exp_stall = l1 + l2;
                w = mem_m[e.addr >> 1];
            end
            if (op == OP_LDB) begin
                bv = (a % 2) ? w[15:8] : w[7:0];
                w  = 16'(signed'(bv));
            end
            exp_mem = w;
        end

        ipacket_in = p;
        alu_in     = a;
        sr_data_in = sr;
        br_addr_in = br;
        cyc = 0; wait_cnt = 0; stalls = 0; prev_stall = 1'b0; done = 1'b0;
        while (!done && cyc < 200) begin
            flush    = (cyc == fl);
            mem_resp = 1'b0;
            if (mem_read || mem_write) begin
                chk("rd_wr_exclusive", 16'(mem_read & mem_write), 16'h0);
                if (acc_q.size() == 0) begin
                    chk("unexpected_access", mem_address, 16'hxxxx);
                    done = 1'b1;
                end else begin
                    if (wait_cnt == 0) begin
                        chk("acc_write", 16'(mem_write), 16'(acc_q[0].wr));
                        chk("acc_addr", mem_address, acc_q[0].addr);
                        chk("acc_byte_en", 16'(mem_byte_en), 16'(acc_q[0].be));
                        if (acc_q[0].wr) chk("acc_wdata", mem_wdata, acc_q[0].wdata);
                    end
                    wait_cnt++;
                    if (wait_cnt == acc_q[0].lat) begin
                        e = acc_q.pop_front();
                        mem_resp  = 1'b1;
                        mem_rdata = e.wr ? 16'($urandom) : mem_m[e.addr >> 1];
                        if (e.wr && e.be[0]) mem_m[e.addr >> 1][7:0]  = e.wdata[7:0];
                        if (e.wr && e.be[1]) mem_m[e.addr >> 1][15:8] = e.wdata[15:8];
                        wait_cnt = 0;
                    end
                end
            end else if ($urandom_range(0, 3) == 0) begin
                mem_resp  = 1'b1;
                mem_rdata = 16'($urandom);
            end
            #1;
            if (prev_stall) chk("bubble_while_stalled", 16'(ipacket_out), 16'(bubble_exp));
            if (stall) stalls++;
            else       done = 1'b1;
            prev_stall = stall;
            @(negedge clk);
            cyc++;
        end
        flush     = 1'b0;
        mem_resp  = 1'b0;
        tot_stall += stalls;

        chk("instr_complete", 16'(done), 16'h1);
        chk("stall_count", 16'(stalls), 16'(exp_stall));
        chk("ipacket_out", 16'(ipacket_out), 16'(fl >= 0 ? bubble_exp : p));
        if (fl < 0) begin
            chk("alu_out", alu_out, a);
            chk("br_addr_out", br_addr_out, br);
            if (ld) chk("mem_out", mem_out, exp_mem);
        end
        chk("strobes_dropped", 16'({mem_read, mem_write}), 16'h0);
        chk("accesses_left", 16'(acc_q.size()), 16'h0);
    endtask

    initial begin
        lc3b_opcode op;
        int         l1, l2, fl;

        bubble_exp        = '0;
        bubble_exp.opcode = OP_BR;
        for (int i = 0; i < 32768; i++) mem_m[i] = 16'($urandom);

        rst        = 1'b1;
        ipacket_in = bubble_exp;
        alu_in     = 16'h0; sr_data_in = 16'h0; br_addr_in = 16'h0;
        flush      = 1'b0; mem_resp = 1'b0; mem_rdata = 16'h0;
        @(negedge clk);
        chk("rst_ipacket_out", 16'(ipacket_out), 16'(bubble_exp));
        chk("rst_alu_out", alu_out, 16'h0);
        chk("rst_mem_out", mem_out, 16'h0);
        chk("rst_br_addr_out", br_addr_out, 16'h0);
        chk("rst_mem_address", mem_address, 16'h0);
        chk("rst_mem_wdata", mem_wdata, 16'h0);
        chk("rst_byte_en", 16'(mem_byte_en), 16'h0);
        chk("rst_strobes", 16'({mem_read, mem_write}), 16'h0);
`ifdef MEM_PERF_CNT_EN
        chk("rst_stall_cycles", 16'(stall_cycles), 16'h0);
`endif
        rst = 1'b0;
        @(negedge clk);

        run_instr(OP_ADD, 16'h1234, 16'h0, 16'h0040, 1, 1, -1);
        mem_m[16'h3000 >> 1] = 16'hBEEF;
        run_instr(OP_LDW, 16'h3001, 16'h0, 16'h0, 4, 1, -1);
        mem_m[16'h2000 >> 1] = 16'h8012;
        run_instr(OP_LDB, 16'h2001, 16'h0, 16'h0, 2, 1, -1);
        run_instr(OP_STB, 16'h2000, 16'h12AB, 16'h0, 1, 1, -1);
        mem_m[16'h4000 >> 1] = 16'h5002;
        mem_m[16'h5002 >> 1] = 16'h1234;
        run_instr(OP_LDI, 16'h4000, 16'h0, 16'h0, 2, 3, -1);
        run_instr(OP_LDI, 16'h4000, 16'h0, 16'h0, 3, 2, 1);
        run_instr(OP_LDW, 16'h3000, 16'h0, 16'h0, 2, 1, 0);
        run_instr(OP_STI, 16'h4000, 16'h7777, 16'h0, 1, 2, 3);
        run_instr(OP_LDW, 16'h3000, 16'h0, 16'h0, 2, 1, 2);

        for (int n = 0; n < 250; n++) begin
            op = lc3b_opcode'(4'($urandom_range(0, 15)));
            l1 = $urandom_range(1, 4);
            l2 = $urandom_range(1, 4);
            if ($urandom_range(0, 9) < 7)
                fl = -1;
            else if (op inside {OP_LDW, OP_LDB, OP_LDI, OP_STW, OP_STB, OP_STI})
                fl = $urandom_range(0, l1 + ((op inside {OP_LDI, OP_STI}) ? l2 : 0));
            else
                fl = 0;
            run_instr(op, 16'($urandom), 16'($urandom), 16'($urandom), l1, l2, fl);
        end

`ifdef MEM_PERF_CNT_EN
        chk("stall_cycles_total", 16'(stall_cycles), 16'(tot_stall));
`endif

        // Reset in the middle of the second access of an LDI.
        mem_m[16'h4000 >> 1] = 16'h5002;
        ipacket_in        = bubble_exp;
        ipacket_in.opcode = OP_LDI;
        ipacket_in.load_regfile = 1'b1;
        alu_in = 16'h4000;
        @(negedge clk);
        chk("rstmid_acc1_read", 16'(mem_read), 16'h1);
        mem_resp  = 1'b1;
        mem_rdata = 16'h5002;
        @(negedge clk);
        mem_resp  = 1'b0;
        chk("rstmid_acc2_read", 16'(mem_read), 16'h1);
        chk("rstmid_acc2_addr", mem_address, 16'h5002);
        #2 rst = 1'b1;
        #1;
        chk("rstmid_strobes", 16'({mem_read, mem_write}), 16'h0);
        chk("rstmid_byte_en", 16'(mem_byte_en), 16'h0);
        chk("rstmid_address", mem_address, 16'h0);
        chk("rstmid_ipacket_out", 16'(ipacket_out), 16'(bubble_exp));
        chk("rstmid_alu_out", alu_out, 16'h0);
        chk("rstmid_mem_out", mem_out, 16'h0);
        ipacket_in = bubble_exp;
        #1;
        chk("rstmid_idle_no_stall", 16'(stall), 16'h0);
`ifdef MEM_PERF_CNT_EN
        chk("rstmid_stall_cycles", 16'(stall_cycles), 16'h0);
`endif
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_strobes", 16'({mem_read, mem_write}), 16'h0);
        run_instr(OP_LDW, 16'h4000, 16'h0, 16'h0, 1, 1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
